// File: rtl/branch_stall_if.sv
// Hazard/control bundle between the ID-stage branch logic and the stall controller.
// The pipeline side drives hazard info (master); the controller returns hold/flush controls (slave).
interface branch_stall_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_branch;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             branch_taken;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             mem_regwrite;
    logic             mem_memread;
    logic [REG_W-1:0] mem_rd;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_branch, id_rs, id_rt, branch_taken,
        output ex_regwrite, ex_memread, ex_rd,
        output mem_regwrite, mem_memread, mem_rd,
        input  pc_hold, ifid_hold, idex_bubble, ifid_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_branch, id_rs, id_rt, branch_taken,
        input  ex_regwrite, ex_memread, ex_rd,
        input  mem_regwrite, mem_memread, mem_rd,
        output pc_hold, ifid_hold, idex_bubble, ifid_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/branch_stall_ctrl.sv
// Stall/flush sequencer for beq resolved in ID: holds PC and IF/ID while a producer in EX/MEM
// is still in flight, flushes IF/ID on a taken branch, and keeps saturating perf counters.
module branch_stall_ctrl #(
    parameter int REG_W          = 5,
    parameter int CNT_W          = 16,
    parameter int ALU_EX_STALL   = 1,
    parameter int LOAD_EX_STALL  = 2,
    parameter int LOAD_MEM_STALL = 1,
    parameter int STALL_W        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_stall_if.slave bus
);
    localparam int NSTAGE = 2;  // 0 = EX, 1 = MEM

    typedef enum logic [0:0] {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [STALL_W-1:0] rem_reg;
    logic [STALL_W-1:0] rem_next;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [CNT_W-1:0]   stall_cnt_next;
    logic [CNT_W-1:0]   flush_cnt_reg;
    logic [CNT_W-1:0]   flush_cnt_next;

    logic               stage_regwrite [NSTAGE];
    logic               stage_memread  [NSTAGE];
    logic [REG_W-1:0]   stage_rd       [NSTAGE];
    logic               stage_hit      [NSTAGE];
    logic [STALL_W-1:0] stage_need     [NSTAGE];
    logic [STALL_W-1:0] need;

    logic               stall_active;
    logic               flush_active;

    assign stage_regwrite[0] = bus.ex_regwrite;
    assign stage_memread[0]  = bus.ex_memread;
    assign stage_rd[0]       = bus.ex_rd;
    assign stage_regwrite[1] = bus.mem_regwrite;
    assign stage_memread[1]  = bus.mem_memread;
    assign stage_rd[1]       = bus.mem_rd;

    // Per-stage requirement; r0 never counts as a producer.
    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
            assign stage_hit[gi] = stage_regwrite[gi] && (stage_rd[gi] != '0) &&
                                   ((stage_rd[gi] == bus.id_rs) || (stage_rd[gi] == bus.id_rt));
            if (gi == 0) begin : g_ex
                assign stage_need[gi] = !stage_hit[gi]    ? '0 :
                                        stage_memread[gi] ? STALL_W'(LOAD_EX_STALL) :
                                                            STALL_W'(ALU_EX_STALL);
            end else begin : g_mem
                assign stage_need[gi] = (stage_hit[gi] && stage_memread[gi]) ?
                                        STALL_W'(LOAD_MEM_STALL) : '0;
            end
        end
    endgenerate

    // Overlapping hazards take the largest requirement, never the sum.
    always_comb begin
        need = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (stage_need[i] > need) begin
                need = stage_need[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE: begin
                if (bus.id_branch && (need != '0)) begin
                    rem_next   = need - STALL_W'(1);
                    state_next = (need == STALL_W'(1)) ? IDLE : STALL;
                end
            end
            STALL: begin
                rem_next = rem_reg - STALL_W'(1);
                // The <= guard keeps a corrupted rem of 0 from wrapping into a long stall.
                if (rem_reg <= STALL_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                rem_next   = '0;
            end
        endcase
    end

    // Controls are gated by rst_n so a reset mid-stall releases the pipeline at once.
    always_comb begin
        stall_active = 1'b0;
        flush_active = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (bus.id_branch && (need != '0)) begin
                        stall_active = 1'b1;
                    end else if (bus.id_branch && bus.branch_taken) begin
                        flush_active = 1'b1;
                    end
                end
                STALL:   stall_active = 1'b1;
                default: stall_active = 1'b0;
            endcase
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall_active && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if (flush_active && (flush_cnt_reg != '1)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.pc_hold     = stall_active;
    assign bus.ifid_hold   = stall_active;
    assign bus.idex_bubble = stall_active;
    assign bus.ifid_flush  = flush_active;
    assign bus.stall_cnt   = stall_cnt_reg;
    assign bus.flush_cnt   = flush_cnt_reg;
endmodule
